// File: rtl/fetch.sv
// CHIP-8 instruction fetch: reads two big-endian bytes per opcode and offers them to execute.
// Optional CHIP8_FETCH_ALIGN_CHECK_EN traps odd redirect targets into a sticky FAULT state.
module fetch #(
    parameter int                 ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'('h200)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    typedef enum logic [2:0] {
        FETCH_HI = 3'd0,
        FETCH_LO = 3'd1,
        WAIT_LO  = 3'd2,
        VALID    = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        hi_byte;
    logic              accept;
    logic              take_redirect;

    assign accept = (state == VALID) && instr_valid && instr_ready;

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    logic bad_redirect;
    assign bad_redirect  = redirect_valid && (redirect_pc[0] || (state == FAULT));
    assign take_redirect = redirect_valid && !bad_redirect;
`else
    assign take_redirect = redirect_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_HI;
        end else begin
            state <= state_next;
        end
    end

    // Memory strobes come straight from the state so the low byte is requested the cycle the high byte lands.
    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        mem_addr   = pc;
        case (state)
            FETCH_HI: begin
                if (!halt) begin
                    mem_rd_en  = 1'b1;
                    state_next = FETCH_LO;
                end
            end
            FETCH_LO: begin
                mem_rd_en  = 1'b1;
                mem_addr   = pc + ADDR_W'(1);
                state_next = WAIT_LO;
            end
            WAIT_LO: state_next = VALID;
            VALID: begin
                if (instr_ready) begin
                    state_next = FETCH_HI;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = FETCH_HI;
        endcase
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
        if (bad_redirect) begin
            state_next = FAULT;
        end
`endif
        if (take_redirect) begin
            state_next = FETCH_HI;
        end
        if (rst) begin
            mem_rd_en = 1'b0;
        end
    end

    // A redirect overrides the handshake's pc+2 but the offered instruction still counts as consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            hi_byte     <= 8'h00;
            instr       <= 16'h0000;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FETCH_LO: hi_byte <= mem_rd_data;
                WAIT_LO: begin
                    instr       <= {hi_byte, mem_rd_data};
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                end
                VALID: begin
                    if (accept) begin
                        pc          <= pc + ADDR_W'(2);
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end
            if (take_redirect) begin
                pc <= redirect_pc;
            end
        end
    end

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (bad_redirect) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed vectors plus a transaction-level model of pc and delivered opcodes.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic [11:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        halt;
    logic [11:0] pc;
    logic        fault;

    logic [7:0]  mem [0:4095];
    int          tests;
    int          fails;

    fetch #(.ADDR_W(12), .RESET_PC(12'h200)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .pc             (pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory with a fixed one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: pc advances by 2 per accepted opcode or jumps on redirect; a valid opcode is the two bytes at instr_pc.
    logic [11:0] expPc;
    logic        faulted;
    logic        holdPrev;
    logic [15:0] prevInstr;
    logic [11:0] nextAddr;

    always @(negedge clk) begin
        if (rst) begin
            expPc    = 12'h200;
            faulted  = 1'b0;
            holdPrev = 1'b0;
        end else begin
            checkOutput("model_pc", {20'd0, pc}, {20'd0, expPc});
            if (instr_valid) begin
                nextAddr = instr_pc + 12'd1;
                checkOutput("model_instr", {16'd0, instr}, {16'd0, mem[instr_pc], mem[nextAddr]});
            end
            if (mem_rd_en) begin
                nextAddr = pc + 12'd1;
                checkOutput("model_rd_addr", {31'd0, (mem_addr == pc) || (mem_addr == nextAddr)}, 32'd1);
            end
            if (holdPrev) begin
                checkOutput("model_hold_valid", {31'd0, instr_valid}, 32'd1);
                checkOutput("model_hold_instr", {16'd0, instr}, {16'd0, prevInstr});
            end
            if (faulted) begin
                checkOutput("model_fault_idle", {30'd0, instr_valid, mem_rd_en}, 32'd0);
            end
            holdPrev  = instr_valid && !instr_ready && !redirect_valid;
            prevInstr = instr;
`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
            if (redirect_valid && (redirect_pc[0] || faulted)) begin
                faulted = 1'b1;
            end else
`endif
            if (redirect_valid) begin
                expPc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
                expPc = expPc + 12'd2;
            end
        end
    end

    task automatic applyStimulus();
        // Reset values while rst is still held.
        rst = 1'b1;
        step();
        step();
        checkOutput("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("rst_addr", {20'd0, mem_addr}, 32'h200);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_instr", {16'd0, instr}, 32'd0);
        checkOutput("rst_instr_pc", {20'd0, instr_pc}, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_pc", {20'd0, pc}, 32'h200);

        // First opcode: reads 0x200, 0x201, valid three cycles later.
        instr_ready = 1'b1;
        rst = 1'b0;
        #1;
        checkOutput("c0_rd_en", {31'd0, mem_rd_en}, 32'd1);
        checkOutput("c0_addr", {20'd0, mem_addr}, 32'h200);
        step();
        checkOutput("c1_rd_en", {31'd0, mem_rd_en}, 32'd1);
        checkOutput("c1_addr", {20'd0, mem_addr}, 32'h201);
        step();
        checkOutput("c2_rd_en", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("c2_valid", {31'd0, instr_valid}, 32'd0);
        step();
        checkOutput("c3_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("c3_instr", {16'd0, instr}, 32'h1234);
        checkOutput("c3_instr_pc", {20'd0, instr_pc}, 32'h200);
        step();
        checkOutput("c4_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("c4_addr", {20'd0, mem_addr}, 32'h202);
        checkOutput("c4_rd_en", {31'd0, mem_rd_en}, 32'd1);

        // Back-pressure for 10 cycles.
        instr_ready = 1'b0;
        step();
        step();
        step();
        checkOutput("bp_instr", {16'd0, instr}, 32'h6A05);
        checkOutput("bp_instr_pc", {20'd0, instr_pc}, 32'h202);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("bp_hold_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("bp_hold_instr", {16'd0, instr}, 32'h6A05);
            checkOutput("bp_no_read", {31'd0, mem_rd_en}, 32'd0);
        end
        instr_ready = 1'b1;
        step();
        checkOutput("bp_accept_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("bp_accept_pc", {20'd0, pc}, 32'h204);

        // Redirect during the low-byte read.
        step();
        checkOutput("rd_lo_addr", {20'd0, mem_addr}, 32'h205);
        redirect_valid = 1'b1;
        redirect_pc = 12'h300;
        step();
        redirect_valid = 1'b0;
        #1;
        checkOutput("redir_addr_hi", {20'd0, mem_addr}, 32'h300);
        checkOutput("redir_valid0", {31'd0, instr_valid}, 32'd0);
        step();
        checkOutput("redir_addr_lo", {20'd0, mem_addr}, 32'h301);
        step();
        checkOutput("redir_wait_valid", {31'd0, instr_valid}, 32'd0);
        step();
        checkOutput("redir_instr_pc", {20'd0, instr_pc}, 32'h300);
        checkOutput("redir_instr", {16'd0, instr}, 32'hA2F0);

        // Wrap-around at the top of memory.
        step();
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFE;
        step();
        redirect_valid = 1'b0;
        #1;
        checkOutput("wrap_addr_ffe", {20'd0, mem_addr}, 32'hFFE);
        step();
        checkOutput("wrap_addr_fff", {20'd0, mem_addr}, 32'hFFF);
        step();
        step();
        checkOutput("wrap_instr", {16'd0, instr}, 32'h00E0);
        step();
        checkOutput("wrap_next_addr", {20'd0, mem_addr}, 32'h000);
        checkOutput("wrap_next_rd_en", {31'd0, mem_rd_en}, 32'd1);
`ifndef CHIP8_FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc = 12'hFFF;
        step();
        redirect_valid = 1'b0;
        #1;
        checkOutput("odd_addr_hi", {20'd0, mem_addr}, 32'hFFF);
        step();
        checkOutput("odd_addr_lo", {20'd0, mem_addr}, 32'h000);
        step();
        step();
        checkOutput("odd_instr_pc", {20'd0, instr_pc}, 32'hFFF);
        checkOutput("odd_instr", {16'd0, instr}, 32'hE05C);
`endif

        // Redirect coinciding with a handshake takes redirect_pc, then halt at accept.
        redirect_valid = 1'b1;
        redirect_pc = 12'h200;
        step();
        redirect_valid = 1'b0;
        #1;
        checkOutput("redir_acc_pc", {20'd0, pc}, 32'h200);
        checkOutput("redir_acc_valid", {31'd0, instr_valid}, 32'd0);
        step();
        step();
        step();
        checkOutput("halt_pre_instr", {16'd0, instr}, 32'h1234);
        halt = 1'b1;
        step();
        checkOutput("halt_acc_pc", {20'd0, pc}, 32'h202);
        for (int i = 0; i < 5; i++) begin
            checkOutput("halt_no_read", {31'd0, mem_rd_en}, 32'd0);
            checkOutput("halt_no_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        halt = 1'b0;
        #1;
        checkOutput("unhalt_rd_en", {31'd0, mem_rd_en}, 32'd1);
        checkOutput("unhalt_addr", {20'd0, mem_addr}, 32'h202);

        // Reset in the middle of a fetch discards it.
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("midrst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("midrst_pc", {20'd0, pc}, 32'h200);
        checkOutput("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_addr", {20'd0, mem_addr}, 32'h200);
        step();
        step();
        step();
        checkOutput("midrst_instr", {16'd0, instr}, 32'h1234);
        checkOutput("midrst_instr_pc", {20'd0, instr_pc}, 32'h200);

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc = 12'h301;
        step();
        redirect_valid = 1'b0;
        #1;
        checkOutput("flt_set", {31'd0, fault}, 32'd1);
        checkOutput("flt_no_read", {31'd0, mem_rd_en}, 32'd0);
        checkOutput("flt_no_valid", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 12'h400;
        step();
        redirect_valid = 1'b0;
        step();
        checkOutput("flt_sticky", {31'd0, fault}, 32'd1);
        checkOutput("flt_sticky_no_read", {31'd0, mem_rd_en}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("flt_cleared", {31'd0, fault}, 32'd0);
        checkOutput("flt_restart_addr", {20'd0, mem_addr}, 32'h200);
`endif
        step();
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'((i * 7) + 3);
        end
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h6A;
        mem[12'h203] = 8'h05;
        mem[12'h300] = 8'hA2;
        mem[12'h301] = 8'hF0;
        mem[12'hFFE] = 8'h00;
        mem[12'hFFF] = 8'hE0;
        mem[12'h000] = 8'h5C;
        mem_rd_data    = 8'h00;
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;
        halt           = 1'b0;
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
